// File: rtl/amf_pkg.sv
// Shared mode encoding and default pixel width for the adaptive median filter pipeline.
package amf_pkg;

  typedef enum logic [1:0] {
    AMF_APPROX = 2'd0,
    AMF_MIN    = 2'd1,
    AMF_MAX    = 2'd2,
    AMF_MODE3  = 2'd3
  } amf_mode_e;

  localparam int AMF_DW_DEF = 8;

endpackage

// File: rtl/amf_sort3.sv
// Combinational unsigned 3-input sorter: min, median and max of a, b, c.
module amf_sort3
  import amf_pkg::*;
#(
  parameter int DW = AMF_DW_DEF
) (
  input  logic [DW-1:0] a_i,
  input  logic [DW-1:0] b_i,
  input  logic [DW-1:0] c_i,
  output logic [DW-1:0] min_o,
  output logic [DW-1:0] med_o,
  output logic [DW-1:0] max_o
);

  logic [DW-1:0] lo_ab;
  logic [DW-1:0] hi_ab;
  logic [DW-1:0] hi_ab_lo_c;

  assign lo_ab      = (a_i < b_i) ? a_i : b_i;
  assign hi_ab      = (a_i < b_i) ? b_i : a_i;
  assign min_o      = (lo_ab < c_i) ? lo_ab : c_i;
  assign max_o      = (hi_ab < c_i) ? c_i : hi_ab;
  // med = max(min(a,b), min(max(a,b), c)); ties collapse onto the shared value
  assign hi_ab_lo_c = (hi_ab < c_i) ? hi_ab : c_i;
  assign med_o      = (lo_ab < hi_ab_lo_c) ? hi_ab_lo_c : lo_ab;

endmodule

// File: rtl/amf_pipe.sv
// Three-stage 3x3 min/max/median filter with a single global stall (adv).
// Build option AMF_EXACT_MEDIAN_EN: mode 3 yields the exact 9-point median instead of p4.
module amf_pipe
  import amf_pkg::*;
#(
  parameter int DW    = AMF_DW_DEF,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [9*DW-1:0]  in_win,
  input  logic [1:0]       in_mode,
  input  logic             in_valid,
  output logic             in_ready,
  output logic [DW-1:0]    out_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [CNT_W-1:0] out_cnt
);

  logic adv;
  logic fire_out;

  logic             vld_p0_q, vld_p1_q, vld_p2_q;
  logic [CNT_W-1:0] cnt_q;

  logic [DW-1:0] rmin_d    [3];
  logic [DW-1:0] rmed_d    [3];
  logic [DW-1:0] rmax_d    [3];
  logic [DW-1:0] rmin_p0_q [3];
  logic [DW-1:0] rmed_p0_q [3];
  logic [DW-1:0] rmax_p0_q [3];
  amf_mode_e     mode_p0_q;

  logic [DW-1:0] min9_d, max9_d, apx_d, m3_d, maxmin_d, minmax_d;
  logic [DW-1:0] min9_p1_q, max9_p1_q, apx_p1_q, m3_p1_q;
  amf_mode_e     mode_p1_q;

  logic [DW-1:0] data_p2_d;
  logic [DW-1:0] data_p2_q;

  logic [DW-1:0] mins_med_unused, meds_min_unused, meds_max_unused, maxs_med_unused;

  assign adv       = !vld_p2_q | out_ready;
  assign fire_out  = vld_p2_q & out_ready;
  assign in_ready  = adv;
  assign out_valid = vld_p2_q;
  assign out_data  = data_p2_q;
  assign out_cnt   = cnt_q;

  // ---- S1: per-row sort ----
  for (genvar r = 0; r < 3; r++) begin : g_row
    amf_sort3 #(.DW(DW)) u_row (
      .a_i  (in_win[(3*r+0)*DW +: DW]),
      .b_i  (in_win[(3*r+1)*DW +: DW]),
      .c_i  (in_win[(3*r+2)*DW +: DW]),
      .min_o(rmin_d[r]),
      .med_o(rmed_d[r]),
      .max_o(rmax_d[r])
    );
  end

  always_ff @(posedge clk) begin
    if (adv) begin
      rmin_p0_q <= rmin_d;
      rmed_p0_q <= rmed_d;
      rmax_p0_q <= rmax_d;
      mode_p0_q <= amf_mode_e'(in_mode);
    end
  end

  // ---- S2: combine row results ----
  amf_sort3 #(.DW(DW)) u_mins (
    .a_i(rmin_p0_q[0]), .b_i(rmin_p0_q[1]), .c_i(rmin_p0_q[2]),
    .min_o(min9_d), .med_o(mins_med_unused), .max_o(maxmin_d)
  );

  amf_sort3 #(.DW(DW)) u_meds (
    .a_i(rmed_p0_q[0]), .b_i(rmed_p0_q[1]), .c_i(rmed_p0_q[2]),
    .min_o(meds_min_unused), .med_o(apx_d), .max_o(meds_max_unused)
  );

  amf_sort3 #(.DW(DW)) u_maxs (
    .a_i(rmax_p0_q[0]), .b_i(rmax_p0_q[1]), .c_i(rmax_p0_q[2]),
    .min_o(minmax_d), .med_o(maxs_med_unused), .max_o(max9_d)
  );

`ifdef AMF_EXACT_MEDIAN_EN
  logic [DW-1:0] exact_min_unused, exact_max_unused;
  logic          unused_bits;

  amf_sort3 #(.DW(DW)) u_exact (
    .a_i(maxmin_d), .b_i(apx_d), .c_i(minmax_d),
    .min_o(exact_min_unused), .med_o(m3_d), .max_o(exact_max_unused)
  );

  assign unused_bits = ^{mins_med_unused, meds_min_unused, meds_max_unused,
                         maxs_med_unused, exact_min_unused, exact_max_unused};
`else
  logic [DW-1:0] p4_p0_q;
  logic          unused_bits;

  // Centre pixel rides alongside S1 so mode 3 can pass it straight through
  always_ff @(posedge clk) begin
    if (adv) p4_p0_q <= in_win[4*DW +: DW];
  end

  assign m3_d        = p4_p0_q;
  assign unused_bits = ^{mins_med_unused, meds_min_unused, meds_max_unused,
                         maxs_med_unused, maxmin_d, minmax_d};
`endif

  always_ff @(posedge clk) begin
    if (adv) begin
      min9_p1_q <= min9_d;
      max9_p1_q <= max9_d;
      apx_p1_q  <= apx_d;
      m3_p1_q   <= m3_d;
      mode_p1_q <= mode_p0_q;
    end
  end

  // ---- S3: mode select into output register ----
  always_comb begin
    data_p2_d = apx_p1_q;
    case (mode_p1_q)
      AMF_MIN:   data_p2_d = min9_p1_q;
      AMF_MAX:   data_p2_d = max9_p1_q;
      AMF_MODE3: data_p2_d = m3_p1_q;
      default:   data_p2_d = apx_p1_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0_q  <= 1'b0;
      vld_p1_q  <= 1'b0;
      vld_p2_q  <= 1'b0;
      data_p2_q <= '0;
      cnt_q     <= '0;
    end else begin
      if (adv) begin
        vld_p0_q  <= in_valid;
        vld_p1_q  <= vld_p0_q;
        vld_p2_q  <= vld_p1_q;
        data_p2_q <= data_p2_d;
      end
      if (fire_out) cnt_q <= cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_amf_pipe.sv
// Directed bench for amf_pipe (DW=12, CNT_W=4) with an in-order expected-result queue.
module tb_amf_pipe;

  localparam int DW    = 12;
  localparam int CNT_W = 4;
`ifdef AMF_EXACT_MEDIAN_EN
  localparam bit EXACT = 1'b1;
`else
  localparam bit EXACT = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst;
  logic [9*DW-1:0]  in_win;
  logic [1:0]       in_mode;
  logic             in_valid;
  logic             in_ready;
  logic [DW-1:0]    out_data;
  logic             out_valid;
  logic             out_ready;
  logic [CNT_W-1:0] out_cnt;

  amf_pipe #(.DW(DW), .CNT_W(CNT_W)) u_dut (
    .clk      (clk),
    .rst      (rst),
    .in_win   (in_win),
    .in_mode  (in_mode),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_cnt  (out_cnt)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] d;
    int          c;
    bit          lat;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_errors = 0;
  int   n_out    = 0;
  int   cyc      = 0;

  int tA[9] = '{10, 20, 30, 40, 50, 60, 70, 80, 90};
  int tB[9] = '{1, 2, 9, 3, 4, 8, 5, 6, 7};
  int tD[9] = '{90, 80, 70, 60, 50, 40, 30, 20, 10};
  int tE[9] = '{7, 7, 7, 7, 7, 7, 7, 7, 7};
  int tC[9] = '{4095, 4095, 4095, 4095, 0, 4095, 4095, 4095, 4095};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [9*DW-1:0] mk(input int p[9]);
    logic [9*DW-1:0] w;
    w = '0;
    for (int k = 0; k < 9; k++) w[k*DW +: DW] = p[k][DW-1:0];
    return w;
  endfunction

  function automatic logic [9*DW-1:0] flat(input int v);
    int p[9];
    for (int k = 0; k < 9; k++) p[k] = v;
    return mk(p);
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard: every consumed result must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (rst) begin
      n_out = 0;
    end else if (out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        check("unexpected_out", out_valid, 1'b0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("data", out_data, e.d);
        if (e.lat) check("latency", cyc, e.c);
      end
      n_out++;
    end
  end

  // Present one window, wait (bounded) for acceptance, then leave in_valid raised.
  task automatic send(input logic [9*DW-1:0] w, input logic [1:0] m, input int e,
                      input bit track, input bit lat);
    int waited;
    exp_t x;
    waited   = 0;
    in_win   = w;
    in_mode  = m;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && waited < 50) begin
      waited++;
      @(negedge clk);
    end
    if (!in_ready) begin
      check("accept_timeout", in_ready, 1'b1);
    end else if (track) begin
      x.d = e; x.c = cyc + 3; x.lat = lat;
      exp_q.push_back(x);
    end
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int waited;
    waited   = 0;
    in_valid = 1'b0;
    while (exp_q.size() != 0 && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    if (exp_q.size() != 0) check("drain_timeout", exp_q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic chk_cnt(input string tag);
    @(negedge clk);
    check(tag, out_cnt, n_out % 16);
    @(posedge clk); #1;
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1);
  end

  int sw_tbl[6] = '{0, 0, 0, 1, 1, 1};
  int sw_mod[6] = '{1, 2, 0, 1, 2, 0};
  int sw_exp[6] = '{10, 90, 50, 1, 9, 4};

  initial begin
    rst = 1'b1; in_valid = 1'b0; in_mode = 2'd0; in_win = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 0);
    check("rst_out_cnt", out_cnt, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("in_ready_after_rst", in_ready, 1'b1);
    @(posedge clk); #1;

    // back-to-back modes, exact 3-cycle latency
    send(mk(tA), 2'd0, 50, 1, 1);
    send(mk(tA), 2'd1, 10, 1, 1);
    send(mk(tA), 2'd2, 90, 1, 1);
    send(mk(tA), 2'd3, 50, 1, 1);
    send(mk(tB), 2'd0, 4, 1, 1);
    send(mk(tB), 2'd3, EXACT ? 5 : 4, 1, 1);
    send(mk(tB), 2'd1, 1, 1, 1);
    send(mk(tB), 2'd2, 9, 1, 1);
    send(mk(tD), 2'd0, 50, 1, 1);
    send(mk(tD), 2'd3, 50, 1, 1);
    for (int m = 0; m < 4; m++) send(mk(tE), m[1:0], 7, 1, 1);
    send(mk(tC), 2'd0, 4095, 1, 1);
    send(mk(tC), 2'd1, 0, 1, 1);
    send(mk(tC), 2'd2, 4095, 1, 1);
    send(mk(tC), 2'd3, EXACT ? 4095 : 0, 1, 1);
    // a bubble between windows must be kept, not collapsed
    in_valid = 1'b0;
    @(posedge clk); #1;
    send(mk(tB), 2'd1, 1, 1, 1);
    in_valid = 1'b0;
    @(posedge clk); #1;
    send(mk(tB), 2'd2, 9, 1, 1);
    drain();
    chk_cnt("cnt_after_directed");

    // downstream stall of 5 cycles with windows in flight
    fork
      begin
        for (int i = 0; i < 6; i++) begin
          if (sw_tbl[i] == 0) send(mk(tA), sw_mod[i][1:0], sw_exp[i], 1, 0);
          else                send(mk(tB), sw_mod[i][1:0], sw_exp[i], 1, 0);
        end
        in_valid = 1'b0;
      end
      begin
        repeat (4) @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int s = 0; s < 5; s++) begin
          @(negedge clk);
          check("stall_in_ready", in_ready, 1'b0);
          check("stall_out_valid", out_valid, 1'b1);
          check("stall_out_data", out_data, 90);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk_cnt("cnt_after_stall");

    // reset with three windows in flight
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) send(mk(tA), 2'd2, 0, 0, 0);
    in_valid = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 1'b0);
    check("mid_rst_out_cnt", out_cnt, 0);
    check("mid_rst_out_data", out_data, 0);
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("no_stale_out", out_valid, 1'b0);
    end
    @(posedge clk); #1;

    // 17 results through a 4-bit counter wraps to 1
    for (int i = 0; i < 17; i++) send(flat(i * 5 + 3), i[1:0], i * 5 + 3, 1, 1);
    drain();
    @(negedge clk);
    check("cnt_wrap", out_cnt, 1);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
